// File: rtl/prog_counter_if.sv
// Control/status bundle between the CPU controller (master) and the program
// counter (slave).
interface prog_counter_if #(
  parameter int unsigned WIDTH = 5
);
  logic [WIDTH-1:0] data;
  logic             load;
  logic             enable;
  logic             call;
  logic             ret;
  logic [WIDTH-1:0] count;
  logic             stack_empty;
  logic             stack_full;
  logic             err;
  logic             tc;

  modport master (
    output data, load, enable, call, ret,
    input  count, stack_empty, stack_full, err, tc
  );

  modport slave (
    input  data, load, enable, call, ret,
    output count, stack_empty, stack_full, err, tc
  );
endinterface

// File: rtl/prog_counter.sv
// Program counter with hardware return-address stack and sticky error flag.
// Define PC_SATURATE_EN to make enable stick at all-ones instead of wrapping.
module prog_counter #(
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned RESET_VAL   = 0
) (
  input logic           clk,
  input logic           rst_,
  prog_counter_if.slave bus
);

  localparam int unsigned SPW = $clog2(STACK_DEPTH) + 1;

  logic [WIDTH-1:0] count_q, count_nxt, count_inc;
  logic [SPW-1:0]   sp_q, sp_nxt;
  logic [SPW-2:0]   top_idx;
  logic             err_q, err_nxt;
  logic             push;
  logic             empty, full;
  logic [WIDTH-1:0] stack [STACK_DEPTH];

  assign count_inc = count_q + WIDTH'(1);
  assign top_idx   = sp_q[SPW-2:0] - (SPW-1)'(1);
  assign empty     = (sp_q == '0);
  assign full      = (sp_q == SPW'(STACK_DEPTH));

  always_comb begin
    count_nxt = count_q;
    sp_nxt    = sp_q;
    err_nxt   = err_q;
    push      = 1'b0;
    if (bus.ret) begin
      if (empty) begin
        err_nxt = 1'b1;
      end else begin
        count_nxt = stack[top_idx];
        sp_nxt    = sp_q - SPW'(1);
      end
    end else if (bus.call) begin
      if (full) begin
        err_nxt = 1'b1;
      end else begin
        push      = 1'b1;
        sp_nxt    = sp_q + SPW'(1);
        count_nxt = bus.data;
      end
    end else if (bus.load) begin
      count_nxt = bus.data;
    end else if (bus.enable) begin
`ifdef PC_SATURATE_EN
      if (!(&count_q)) count_nxt = count_inc;
`else
      count_nxt = count_inc;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      count_q <= WIDTH'(RESET_VAL);
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_nxt;
      sp_q    <= sp_nxt;
      err_q   <= err_nxt;
    end
  end

  // Return address always wraps, even in the saturating build.
  always_ff @(posedge clk) begin
    if (rst_ && push) stack[sp_q[SPW-2:0]] <= count_inc;
  end

  assign bus.count       = count_q;
  assign bus.stack_empty = empty;
  assign bus.stack_full  = full;
  assign bus.err         = err_q;
  assign bus.tc          = &count_q;

endmodule

// File: tb/tb_prog_counter.sv
// Self-checking bench for prog_counter: table-driven vectors with a scoreboard
// queue of expected {count, empty, full, err, tc} per applied cycle.
module tb_prog_counter;

  logic clk = 1'b0;
  logic rst_;

  always #5 clk = ~clk;

  prog_counter_if #(.WIDTH(5)) bus ();

  prog_counter #(
    .WIDTH       (5),
    .STACK_DEPTH (4),
    .RESET_VAL   (0)
  ) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

`ifdef PC_SATURATE_EN
  localparam logic [4:0] WRAP_CNT = 5'h1F;
  localparam logic       WRAP_TC  = 1'b1;
`else
  localparam logic [4:0] WRAP_CNT = 5'h00;
  localparam logic       WRAP_TC  = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic       rst_;
    logic       ld, en, cl, rt;
    logic [4:0] data;
    logic [8:0] exp;   // {count, empty, full, err, tc}
  } vec_t;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string tag, logic r, logic ld, logic en, logic cl,
                              logic rt, logic [4:0] d, logic [4:0] c, logic e,
                              logic f, logic er, logic t);
    vec_t v;
    v.tag = tag; v.rst_ = r; v.ld = ld; v.en = en; v.cl = cl; v.rt = rt;
    v.data = d; v.exp = {c, e, f, er, t};
    return v;
  endfunction

  task automatic apply(input vec_t v);
    sb_t s;
    @(negedge clk);
    rst_       = v.rst_;
    bus.load   = v.ld;
    bus.enable = v.en;
    bus.call   = v.cl;
    bus.ret    = v.rt;
    bus.data   = v.data;
    s.tag = v.tag;
    s.exp = v.exp;
    sb.push_back(s);
  endtask

  sb_t        cur;
  logic [8:0] got;

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      got = {bus.count, bus.stack_empty, bus.stack_full, bus.err, bus.tc};
      n_vec++;
      if (got !== cur.exp) begin
        n_bad++;
        $display("FAIL %s: got count=%h empty=%b full=%b err=%b tc=%b, want count=%h empty=%b full=%b err=%b tc=%b",
                 cur.tag, got[8:4], got[3], got[2], got[1], got[0],
                 cur.exp[8:4], cur.exp[3], cur.exp[2], cur.exp[1], cur.exp[0]);
      end
    end
  end

  initial begin
    rst_ = 1'b1;
    bus.load = 1'b0; bus.enable = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    bus.data = '0;

    //              tag          rst ld en cl rt data    count  e  f  er tc
    tbl.push_back(mk("reset",     0, 0, 0, 0, 0, 5'h00, 5'h00, 1, 0, 0, 0));
    tbl.push_back(mk("inc1",      1, 0, 1, 0, 0, 5'h00, 5'h01, 1, 0, 0, 0));
    tbl.push_back(mk("inc2",      1, 0, 1, 0, 0, 5'h00, 5'h02, 1, 0, 0, 0));
    tbl.push_back(mk("inc3",      1, 0, 1, 0, 0, 5'h00, 5'h03, 1, 0, 0, 0));
    tbl.push_back(mk("call10",    1, 0, 0, 1, 0, 5'h0A, 5'h0A, 0, 0, 0, 0));
    tbl.push_back(mk("inc_sub",   1, 0, 1, 0, 0, 5'h00, 5'h0B, 0, 0, 0, 0));
    tbl.push_back(mk("ret4",      1, 0, 0, 0, 1, 5'h00, 5'h04, 1, 0, 0, 0));
    tbl.push_back(mk("load1e",    1, 1, 0, 0, 0, 5'h1E, 5'h1E, 1, 0, 0, 0));
    tbl.push_back(mk("inc1f",     1, 0, 1, 0, 0, 5'h00, 5'h1F, 1, 0, 0, 1));
    tbl.push_back(mk("wrap",      1, 0, 1, 0, 0, 5'h00, WRAP_CNT, 1, 0, 0, WRAP_TC));
    tbl.push_back(mk("reset2",    0, 0, 1, 0, 0, 5'h00, 5'h00, 1, 0, 0, 0));
    tbl.push_back(mk("push_a",    1, 0, 0, 1, 0, 5'h03, 5'h03, 0, 0, 0, 0));
    tbl.push_back(mk("push_b",    1, 0, 0, 1, 0, 5'h05, 5'h05, 0, 0, 0, 0));
    tbl.push_back(mk("push_c",    1, 0, 0, 1, 0, 5'h08, 5'h08, 0, 0, 0, 0));
    tbl.push_back(mk("push_d",    1, 0, 0, 1, 0, 5'h0C, 5'h0C, 0, 1, 0, 0));
    tbl.push_back(mk("overflow",  1, 0, 0, 1, 0, 5'h07, 5'h0C, 0, 1, 1, 0));
    tbl.push_back(mk("pop_d",     1, 0, 0, 0, 1, 5'h00, 5'h09, 0, 0, 1, 0));
    tbl.push_back(mk("pop_c",     1, 0, 0, 0, 1, 5'h00, 5'h06, 0, 0, 1, 0));
    tbl.push_back(mk("pop_b",     1, 0, 0, 0, 1, 5'h00, 5'h04, 0, 0, 1, 0));
    tbl.push_back(mk("pop_a",     1, 0, 0, 0, 1, 5'h00, 5'h01, 1, 0, 1, 0));
    tbl.push_back(mk("reset3",    0, 0, 0, 0, 0, 5'h00, 5'h00, 1, 0, 0, 0));
    tbl.push_back(mk("prio_ret",  1, 1, 0, 1, 1, 5'h05, 5'h00, 1, 0, 1, 0));
    tbl.push_back(mk("prio_call", 1, 1, 1, 1, 0, 5'h09, 5'h09, 0, 0, 1, 0));
    tbl.push_back(mk("ret_b2b",   1, 0, 0, 0, 1, 5'h00, 5'h01, 1, 0, 1, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Reset mid-stack discards pending entries; the next ret underflows.
    apply(mk("reset4",      0, 0, 0, 0, 0, 5'h00, 5'h00, 1, 0, 0, 0));
    apply(mk("mid_call1",   1, 0, 0, 1, 0, 5'h14, 5'h14, 0, 0, 0, 0));
    apply(mk("mid_call2",   1, 0, 0, 1, 0, 5'h19, 5'h19, 0, 0, 0, 0));
    apply(mk("rst_w_ret",   0, 0, 0, 0, 1, 5'h00, 5'h00, 1, 0, 0, 0));
    apply(mk("post_rst_rt", 1, 0, 0, 0, 1, 5'h00, 5'h00, 1, 0, 1, 0));

    // Call from all-ones: return address wraps to 0 in both builds.
    apply(mk("reset5",      0, 0, 0, 0, 0, 5'h00, 5'h00, 1, 0, 0, 0));
    apply(mk("load1f",      1, 1, 0, 0, 0, 5'h1F, 5'h1F, 1, 0, 0, 1));
    apply(mk("call_at_1f",  1, 0, 0, 1, 0, 5'h02, 5'h02, 0, 0, 0, 0));
    apply(mk("ret_wrap",    1, 0, 0, 0, 1, 5'h00, 5'h00, 1, 0, 0, 0));

    // load beats enable, then idle cycles hold everything.
    apply(mk("load_vs_en",  1, 1, 1, 0, 0, 5'h06, 5'h06, 1, 0, 0, 0));
    apply(mk("hold1",       1, 0, 0, 0, 0, 5'h11, 5'h06, 1, 0, 0, 0));
    apply(mk("hold2",       1, 0, 0, 0, 0, 5'h1F, 5'h06, 1, 0, 0, 0));

    @(negedge clk);
    bus.load = 1'b0; bus.enable = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
    repeat (3) @(negedge clk);

    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
